sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares the single 32-bit external SRAM between instruction fetch (IF) and the data memory stage (MEM).
- Runs the SRAM read and write timing sequences.
- Returns data and a one-cycle ready pulse to each requester.
- Drives stall requests into the pipeline controller while a requester is waiting. Sits between the if/mem stages and the SRAM pins.

Parameters:
- ADDR_W, 20, SRAM word-address width; byte address bits [ADDR_W+1:2] select the word.
- READ_WAIT, 1, extra wait cycles in RD after address launch (0..7).
- WE_PULSE, 1, cycles sram_we_n is held low in WR_PULSE (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush from controller
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word
- if_ready  out  1  one-cycle fetch completion pulse
- mem_req  in  1  data request
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data
- mem_sel  in  4  byte enables, active-high
- mem_rdata  out  32  load data
- mem_ready  out  1  one-cycle data completion pulse
- stallreq_if  out  1  if_req && !if_ready
- stallreq_mem  out  1  mem_req && !mem_ready
- sram_addr  out  ADDR_W  word address
- sram_dq_o  out  32  write data
- sram_dq_i  in  32  read data
- sram_dq_oe  out  1  drive data bus
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low
- sram_be_n  out  4  byte enables, active-low

Behaviour:
- Reset: state IDLE, wait counter 0.
  - if_rdata = mem_rdata = 0; if_ready = mem_ready = 0.
  - sram_ce_n = sram_oe_n = sram_we_n = 1; sram_be_n = 4'hF; sram_dq_oe = 0; sram_addr = 0; sram_dq_o = 0.
  - Reset mid-transaction aborts immediately, including a write in WR_PULSE; we_n returns high next edge.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE arbitration, fixed priority, MEM over IF (MEM is the older instruction). Grant latches requester id, address, wdata and sel into registers. Requester inputs are not re-sampled after the grant.
  - mem_req && mem_we -> WR_SETUP
  - mem_req && !mem_we -> RD
  - else if_req -> RD
  - IF reads use be_n = 0.
- RD:
  - ce_n = 0, oe_n = 0, be_n = ~sel.
  - Stays 1+READ_WAIT cycles.
  - On the last cycle, sram_dq_i is captured into the granted requester's rdata register -> DONE.
- WR_SETUP (1 cycle): ce_n = 0, dq_oe = 1, addr/data/be valid, we_n = 1.
- WR_PULSE: we_n = 0 for WE_PULSE cycles.
- WR_HOLD (1 cycle): we_n = 1, data still driven -> DONE.
- DONE:
  - Pulse the granted requester's ready for exactly one cycle; all SRAM strobes inactive.
  - Next state IDLE.
  - rdata holds its value until the next capture.
  - Back-to-back requests therefore have one idle turnaround cycle.
- Latency from grant cycle to ready:
  - read: 2+READ_WAIT cycles
  - write: 3+WE_PULSE cycles
- Requester contract: hold req, addr, we, wdata and sel stable until ready. Reissuing after ready is a new transaction.
- flush:
  - In RD: read aborted, next state IDLE, no ready pulse.
  - In any write state: ignored; the write completes and mem_ready still pulses.
  - In IDLE: no grant that cycle.
- A request dropped without flush mid-read is still completed and ready still pulses; the requester ignores it.
- Simultaneous IF and MEM requests: MEM is served first, and IF waits with stallreq_if high.
- stallreq_if and stallreq_mem are combinational from req and ready.
- Unaligned addresses are not checked; bits [1:0] are ignored.

Optional Feature:
- Macro ARB_IFETCH_BUF_EN.
- Defined:
  - Adds a one-entry fetch buffer (valid, word address, data), filled on each completed IF read.
  - In IDLE, if_req with a matching valid address and no mem_req pulses if_ready the next cycle with the buffered data and makes no SRAM access.
  - A MEM write to the buffered word clears valid when it enters DONE; so do reset and flush.
- Undefined: no buffer, and every fetch goes to the SRAM.

Test Plan:
- READ_WAIT=1; IF read of 0x80000010 with sram_dq_i=0x3C01DEAD -> sram_addr=0x00004, ce_n/oe_n low for 2 cycles, if_ready pulses on cycle 3 with if_rdata=0x3C01DEAD, stallreq_if high for cycles 0-2.
- MEM write 0x80000020, wdata=0x12345678, sel=4'b0011, WE_PULSE=1 -> setup 1, we_n low 1, hold 1, be_n=4'b1100, dq_oe high 3 cycles, mem_ready on cycle 4.
- if_req and mem_req (read) both high -> MEM granted first, mem_ready at cycle 3, if_ready at cycle 7, stallreq_if high throughout.
- flush asserted during RD for IF -> no if_ready, state IDLE next cycle. flush during WR_PULSE -> write completes and mem_ready pulses.
- rst asserted during WR_PULSE -> we_n=1, ce_n=1, dq_oe=0 after the edge, no ready pulse.
- With ARB_IFETCH_BUF_EN: fetch 0x80000010 twice -> second fetch gives if_ready 1 cycle after request with no ce_n activity. Write to 0x80000010 then fetch again -> SRAM is accessed.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one 32-bit async SRAM between instruction fetch and the MEM stage.
// Latency: grant to ready is 2+READ_WAIT cycles for reads, 3+WE_PULSE cycles for writes.
// Backpressure: a waiting requester raises stallreq_* until its one-cycle ready pulse.
// Optional: define ARB_IFETCH_BUF_EN to add a one-entry fetch buffer that bypasses the SRAM.
module sram_bus_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int READ_WAIT = 1,
  parameter int WE_PULSE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_sel,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic                gnt_mem_q;   // 1 = MEM owns the current transaction
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [31:0]         sram_dq_o_q;
  logic                sram_dq_oe_q;
  logic                sram_ce_n_q;
  logic                sram_oe_n_q;
  logic                sram_we_n_q;
  logic [3:0]          sram_be_n_q;
  logic [31:0]         if_rdata_q;
  logic [31:0]         mem_rdata_q;
  logic                if_ready_q;
  logic                mem_ready_q;

  logic [ADDR_W-1:0]   if_waddr;
  logic [ADDR_W-1:0]   mem_waddr;
  logic                unused_addr_bits;

  // Byte address bits [1:0] and the bits above the SRAM window are don't-care.
  assign if_waddr         = if_addr[ADDR_W+1:2];
  assign mem_waddr        = mem_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

`ifdef ARB_IFETCH_BUF_EN
  logic              buf_vld_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [31:0]       buf_dat_q;
  logic              buf_hit;
  assign buf_hit = buf_vld_q && (buf_addr_q == if_waddr);
`endif

  assign stallreq_if  = if_req  && !if_ready_q;
  assign stallreq_mem = mem_req && !mem_ready_q;

  assign if_rdata   = if_rdata_q;
  assign if_ready   = if_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ready  = mem_ready_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = sram_dq_o_q;
  assign sram_dq_oe = sram_dq_oe_q;
  assign sram_ce_n  = sram_ce_n_q;
  assign sram_oe_n  = sram_oe_n_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_be_n  = sram_be_n_q;

  // Arbitration FSM with registered SRAM strobes, read capture and ready pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_mem_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
      sram_ce_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
      sram_be_n_q  <= 4'hF;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
`ifdef ARB_IFETCH_BUF_EN
      buf_vld_q    <= 1'b0;
      buf_addr_q   <= '0;
      buf_dat_q    <= '0;
`endif
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
`ifdef ARB_IFETCH_BUF_EN
      if (flush) buf_vld_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // MEM wins ties: it belongs to the older instruction.
          if (!flush) begin
            if (mem_req) begin
              gnt_mem_q   <= 1'b1;
              sram_addr_q <= mem_waddr;
              sram_be_n_q <= ~mem_sel;
              sram_ce_n_q <= 1'b0;
              cnt_q       <= '0;
              if (mem_we) begin
                state_q      <= WR_SETUP;
                sram_dq_o_q  <= mem_wdata;
                sram_dq_oe_q <= 1'b1;
              end else begin
                state_q     <= RD;
                sram_oe_n_q <= 1'b0;
              end
            end else if (if_req) begin
              gnt_mem_q <= 1'b0;
`ifdef ARB_IFETCH_BUF_EN
              if (buf_hit) begin
                state_q    <= DONE;
                if_ready_q <= 1'b1;
                if_rdata_q <= buf_dat_q;
              end else
`endif
              begin
                state_q     <= RD;
                sram_addr_q <= if_waddr;
                sram_be_n_q <= 4'h0;
                sram_ce_n_q <= 1'b0;
                sram_oe_n_q <= 1'b0;
                cnt_q       <= '0;
              end
            end
          end
        end
        RD: begin
          if (flush) begin
            state_q     <= IDLE;
            sram_ce_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
            sram_be_n_q <= 4'hF;
          end else if (cnt_q == 3'(READ_WAIT)) begin
            state_q     <= DONE;
            sram_ce_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
            sram_be_n_q <= 4'hF;
            if (gnt_mem_q) begin
              mem_rdata_q <= sram_dq_i;
              mem_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= sram_dq_i;
              if_ready_q <= 1'b1;
`ifdef ARB_IFETCH_BUF_EN
              buf_vld_q  <= 1'b1;
              buf_addr_q <= sram_addr_q;
              buf_dat_q  <= sram_dq_i;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        WR_SETUP: begin
          state_q     <= WR_PULSE;
          sram_we_n_q <= 1'b0;
          cnt_q       <= '0;
        end
        WR_PULSE: begin
          // Writes are never abandoned once started; flush is ignored here.
          if (cnt_q == 3'(WE_PULSE - 1)) begin
            state_q     <= WR_HOLD;
            sram_we_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        WR_HOLD: begin
          state_q      <= DONE;
          sram_ce_n_q  <= 1'b1;
          sram_dq_oe_q <= 1'b0;
          sram_be_n_q  <= 4'hF;
          mem_ready_q  <= 1'b1;
`ifdef ARB_IFETCH_BUF_EN
          if (buf_addr_q == sram_addr_q) buf_vld_q <= 1'b0;
`endif
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with READ_WAIT=1, WE_PULSE=1.
// Inputs change and outputs are sampled 1-2 time units after each rising edge.
module tb_sram_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        if_req, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  logic        stallreq_if, stallreq_mem;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  int n_chk  = 0;
  int n_fail = 0;

  sram_bus_arbiter #(.ADDR_W(20), .READ_WAIT(1), .WE_PULSE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
    sram_dq_i = '0;
    step(); step();

    // Reset state
    chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
    chk("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
    chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("rst_be_n", {28'b0, sram_be_n}, 32'hF);
    chk("rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("rst_addr", {12'b0, sram_addr}, 32'd0);
    chk("rst_dq_o", sram_dq_o, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    step();

    // IF read of 0x80000010
    if_req = 1'b1; if_addr = 32'h8000_0010; sram_dq_i = 32'h3C01_DEAD; #1;
    chk("ifrd_c0_stall", {31'b0, stallreq_if}, 32'd1);
    chk("ifrd_c0_ce_n", {31'b0, sram_ce_n}, 32'd1);
    step();
    chk("ifrd_c1_ce_n", {31'b0, sram_ce_n}, 32'd0);
    chk("ifrd_c1_oe_n", {31'b0, sram_oe_n}, 32'd0);
    chk("ifrd_c1_addr", {12'b0, sram_addr}, 32'h4);
    chk("ifrd_c1_be_n", {28'b0, sram_be_n}, 32'h0);
    chk("ifrd_c1_stall", {31'b0, stallreq_if}, 32'd1);
    step();
    chk("ifrd_c2_ce_n", {31'b0, sram_ce_n}, 32'd0);
    chk("ifrd_c2_ready", {31'b0, if_ready}, 32'd0);
    chk("ifrd_c2_stall", {31'b0, stallreq_if}, 32'd1);
    step();
    chk("ifrd_c3_ready", {31'b0, if_ready}, 32'd1);
    chk("ifrd_c3_rdata", if_rdata, 32'h3C01_DEAD);
    chk("ifrd_c3_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("ifrd_c3_stall", {31'b0, stallreq_if}, 32'd0);
    if_req = 1'b0;
    step();
    chk("ifrd_c4_ready", {31'b0, if_ready}, 32'd0);
    chk("ifrd_c4_rdata_hold", if_rdata, 32'h3C01_DEAD);

    // MEM write 0x80000020, sel 0011
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0020;
    mem_wdata = 32'h1234_5678; mem_sel = 4'b0011; #1;
    chk("wr_c0_stall", {31'b0, stallreq_mem}, 32'd1);
    step();
    chk("wr_c1_ce_n", {31'b0, sram_ce_n}, 32'd0);
    chk("wr_c1_dq_oe", {31'b0, sram_dq_oe}, 32'd1);
    chk("wr_c1_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("wr_c1_oe_n", {31'b0, sram_oe_n}, 32'd1);
    chk("wr_c1_be_n", {28'b0, sram_be_n}, 32'hC);
    chk("wr_c1_addr", {12'b0, sram_addr}, 32'h8);
    chk("wr_c1_dq_o", sram_dq_o, 32'h1234_5678);
    step();
    chk("wr_c2_we_n", {31'b0, sram_we_n}, 32'd0);
    chk("wr_c2_dq_oe", {31'b0, sram_dq_oe}, 32'd1);
    step();
    chk("wr_c3_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("wr_c3_dq_oe", {31'b0, sram_dq_oe}, 32'd1);
    chk("wr_c3_ce_n", {31'b0, sram_ce_n}, 32'd0);
    chk("wr_c3_ready", {31'b0, mem_ready}, 32'd0);
    step();
    chk("wr_c4_ready", {31'b0, mem_ready}, 32'd1);
    chk("wr_c4_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("wr_c4_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("wr_c4_stall", {31'b0, stallreq_mem}, 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    chk("wr_c5_ready", {31'b0, mem_ready}, 32'd0);

    // Simultaneous IF and MEM read: MEM first
    if_req = 1'b1; if_addr = 32'h8000_0014;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0040; mem_sel = 4'hF;
    sram_dq_i = 32'hAAAA_5555; #1;
    chk("both_c0_stall_if", {31'b0, stallreq_if}, 32'd1);
    chk("both_c0_stall_mem", {31'b0, stallreq_mem}, 32'd1);
    step();
    chk("both_c1_addr", {12'b0, sram_addr}, 32'h10);
    chk("both_c1_be_n", {28'b0, sram_be_n}, 32'h0);
    chk("both_c1_oe_n", {31'b0, sram_oe_n}, 32'd0);
    step(); step();
    chk("both_c3_mem_ready", {31'b0, mem_ready}, 32'd1);
    chk("both_c3_mem_rdata", mem_rdata, 32'hAAAA_5555);
    chk("both_c3_if_ready", {31'b0, if_ready}, 32'd0);
    chk("both_c3_stall_if", {31'b0, stallreq_if}, 32'd1);
    mem_req = 1'b0; sram_dq_i = 32'h1111_2222;
    step();
    chk("both_c4_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("both_c4_stall_if", {31'b0, stallreq_if}, 32'd1);
    step();
    chk("both_c5_addr", {12'b0, sram_addr}, 32'h5);
    chk("both_c5_ce_n", {31'b0, sram_ce_n}, 32'd0);
    step();
    chk("both_c6_if_ready", {31'b0, if_ready}, 32'd0);
    chk("both_c6_stall_if", {31'b0, stallreq_if}, 32'd1);
    step();
    chk("both_c7_if_ready", {31'b0, if_ready}, 32'd1);
    chk("both_c7_if_rdata", if_rdata, 32'h1111_2222);
    chk("both_c7_mem_rdata_hold", mem_rdata, 32'hAAAA_5555);
    if_req = 1'b0;
    step();

    // flush in IDLE blocks the grant; flush in RD aborts the read
    if_req = 1'b1; if_addr = 32'h8000_0018; flush = 1'b1;
    step();
    chk("fl_idle_ce_n", {31'b0, sram_ce_n}, 32'd1);
    flush = 1'b0;
    step();
    chk("fl_rd_c1_ce_n", {31'b0, sram_ce_n}, 32'd0);
    flush = 1'b1;
    step();
    chk("fl_rd_c2_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("fl_rd_c2_oe_n", {31'b0, sram_oe_n}, 32'd1);
    chk("fl_rd_c2_ready", {31'b0, if_ready}, 32'd0);
    flush = 1'b0; if_req = 1'b0;
    step();
    chk("fl_rd_c3_ready", {31'b0, if_ready}, 32'd0);
    chk("fl_rd_c3_ce_n", {31'b0, sram_ce_n}, 32'd1);
    step();
    chk("fl_rd_c4_ready", {31'b0, if_ready}, 32'd0);

    // MEM read whose request drops mid-read still completes
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0080; mem_sel = 4'b0101;
    sram_dq_i = 32'hCAFE_F00D;
    step();
    chk("drop_c1_be_n", {28'b0, sram_be_n}, 32'hA);
    mem_req = 1'b0;
    step(); step();
    chk("drop_c3_ready", {31'b0, mem_ready}, 32'd1);
    chk("drop_c3_rdata", mem_rdata, 32'hCAFE_F00D);
    step();
    chk("drop_c4_ready", {31'b0, mem_ready}, 32'd0);

    // flush during WR_PULSE is ignored
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0030;
    mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF;
    step(); step();
    chk("flwr_c2_we_n", {31'b0, sram_we_n}, 32'd0);
    flush = 1'b1;
    step();
    chk("flwr_c3_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("flwr_c3_dq_oe", {31'b0, sram_dq_oe}, 32'd1);
    flush = 1'b0;
    step();
    chk("flwr_c4_ready", {31'b0, mem_ready}, 32'd1);
    mem_req = 1'b0; mem_we = 1'b0;
    step();

    // Reset during WR_PULSE aborts the write
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0034;
    mem_wdata = 32'h0BAD_F00D; mem_sel = 4'hF;
    step(); step();
    chk("rstwr_c2_we_n", {31'b0, sram_we_n}, 32'd0);
    rst = 1'b1;
    step();
    chk("rstwr_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("rstwr_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("rstwr_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("rstwr_be_n", {28'b0, sram_be_n}, 32'hF);
    chk("rstwr_addr", {12'b0, sram_addr}, 32'd0);
    chk("rstwr_ready", {31'b0, mem_ready}, 32'd0);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    step();
    chk("rstwr_post1_ready", {31'b0, mem_ready}, 32'd0);
    chk("rstwr_post1_ce_n", {31'b0, sram_ce_n}, 32'd1);
    step();
    chk("rstwr_post2_ready", {31'b0, mem_ready}, 32'd0);

`ifdef ARB_IFETCH_BUF_EN
    // Fetch buffer: first fetch fills, second hits, write invalidates
    if_req = 1'b1; if_addr = 32'h8000_0010; sram_dq_i = 32'h3C01_DEAD;
    step(); step(); step();
    chk("buf_fill_ready", {31'b0, if_ready}, 32'd1);
    if_req = 1'b0;
    step();
    if_req = 1'b1; sram_dq_i = 32'h0;
    step();
    chk("buf_hit_ready", {31'b0, if_ready}, 32'd1);
    chk("buf_hit_rdata", if_rdata, 32'h3C01_DEAD);
    chk("buf_hit_ce_n", {31'b0, sram_ce_n}, 32'd1);
    if_req = 1'b0;
    step();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0010;
    mem_wdata = 32'h5555_0000; mem_sel = 4'hF;
    step(); step(); step(); step();
    chk("buf_wr_ready", {31'b0, mem_ready}, 32'd1);
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    if_req = 1'b1; sram_dq_i = 32'h0000_0055;
    step();
    chk("buf_miss_ce_n", {31'b0, sram_ce_n}, 32'd0);
    chk("buf_miss_ready", {31'b0, if_ready}, 32'd0);
    step(); step();
    chk("buf_miss_c3_ready", {31'b0, if_ready}, 32'd1);
    chk("buf_miss_c3_rdata", if_rdata, 32'h0000_0055);
    if_req = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
